// File: rtl/random_note_sequencer.sv
// Random melody sequencer: requests fresh random length/note values, plays a
// note for 1-4 beats, then a silent gap. It repeats while play_en is held.
module random_note_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_en,
    input  logic [1:0] rand_length,
    input  logic [3:0] rand_note,
    output logic       Enable_rand,
    output logic [3:0] note_out,
    output logic       note_on,
    output logic       note_done,
    output logic [7:0] note_count
);

    typedef enum logic [2:0] {IDLE, REQ, LATCH, PLAY, GAP} state_t;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    // With one-cycle beats the terminal cycle is known one beat early.
    localparam logic             BEAT_ONE  = (BEAT_CYCLES == 1);

    state_t           state;
    logic             armed;      // play_en seen once in IDLE; start on the next edge
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       beats_left;

    // Sequencer FSM; every output is computed as a next-state value and registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            cyc_cnt     <= '0;
            beats_left  <= '0;
            Enable_rand <= 1'b0;
            note_out    <= '0;
            note_on     <= 1'b0;
            note_done   <= 1'b0;
            note_count  <= '0;
        end else begin
            Enable_rand <= 1'b0;
            note_done   <= 1'b0;
            if (state == IDLE) begin
                note_on <= 1'b0;
                if (play_en && armed) begin
                    state       <= REQ;
                    Enable_rand <= 1'b1;
                    armed       <= 1'b0;
                end else begin
                    armed <= play_en;
                end
            end else if (!play_en) begin
                // Stop wins over any terminal count: the note is abandoned uncounted.
                state   <= IDLE;
                note_on <= 1'b0;
                armed   <= 1'b0;
                cyc_cnt <= '0;
            end else begin
                case (state)
                    REQ: state <= LATCH;
                    LATCH: begin
                        beats_left <= {1'b0, rand_length} + 3'd1;
                        note_out   <= (rand_note >= 4'd12) ? rand_note - 4'd12 : rand_note;
                        cyc_cnt    <= '0;
                        note_on    <= 1'b1;
                        note_done  <= BEAT_ONE && (rand_length == 2'd0);
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (cyc_cnt == BEAT_LAST) begin
                            cyc_cnt <= '0;
                            if (beats_left == 3'd1) begin
                                state      <= GAP;
                                note_on    <= 1'b0;
                                note_count <= note_count + 8'd1;
                            end else begin
                                beats_left <= beats_left - 3'd1;
                                note_done  <= BEAT_ONE && (beats_left == 3'd2);
                            end
                        end else begin
                            cyc_cnt   <= cyc_cnt + 1'b1;
                            note_done <= (cyc_cnt == BEAT_LAST - 1'b1) && (beats_left == 3'd1);
                        end
                    end
                    GAP: begin
                        if (cyc_cnt == GAP_LAST) begin
                            cyc_cnt     <= '0;
                            state       <= REQ;
                            Enable_rand <= 1'b1;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_random_note_sequencer.sv
// Bench for random_note_sequencer: directed scenarios plus random play, all
// checked each cycle against a timeline model of one note period.
module tb_random_note_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_en;
    logic [1:0] rand_length;
    logic [3:0] rand_note;
    logic       Enable_rand;
    logic [3:0] note_out;
    logic       note_on;
    logic       note_done;
    logic [7:0] note_count;

    always #5 clk = ~clk;

    random_note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .play_en(play_en), .rand_length(rand_length),
        .rand_note(rand_note), .Enable_rand(Enable_rand), .note_out(note_out),
        .note_on(note_on), .note_done(note_done), .note_count(note_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: position p inside a period measured from the request cycle:
    // p=0 request, p=1 latch, p=2..len+1 sounding, then GAP silent cycles.
    bit m_active, m_armed;
    int p, len, m_note, m_count;
    int done_seen, er_seen, on_run, last_run;

    function automatic void model_reset();
        m_active = 0; m_armed = 0; p = 0; len = 0; m_note = 0; m_count = 0;
    endfunction

    function automatic void model_edge(bit pe, logic [1:0] rl, logic [3:0] rn);
        if (!m_active) begin
            if (pe && m_armed) begin m_active = 1; p = 0; m_armed = 0; end
            else m_armed = pe;
        end else if (!pe) begin
            m_active = 0; m_armed = 0;
        end else begin
            if (p == 1) begin len = (int'(rl) + 1) * BEAT; m_note = int'(rn) % 12; end
            if (p == 1 + len) m_count = (m_count + 1) % 256;
            p++;
            if (p == 2 + len + GAP) p = 0;
        end
    endfunction

    function automatic logic [14:0] model_out();
        logic er, on, dn;
        er = m_active && p == 0;
        on = m_active && p >= 2 && p < 2 + len;
        dn = m_active && len > 0 && p == 1 + len;
        return {er, on, dn, 4'(m_note), 8'(m_count)};
    endfunction

    task automatic check(string tag);
        logic [14:0] obs, exp;
        obs = {Enable_rand, note_on, note_done, note_out, note_count};
        exp = model_out();
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: er/on/done/note/cnt got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                   tag, obs[14], obs[13], obs[12], obs[11:8], obs[7:0],
                   exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic expect_int(string tag, int got, int want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step(string tag);
        bit rs, pe;
        logic [1:0] rl;
        logic [3:0] rn;
        rs = reset; pe = play_en; rl = rand_length; rn = rand_note;
        @(posedge clk);
        #1;
        if (!rs) model_reset();
        else model_edge(pe, rl, rn);
        check(tag);
        if (Enable_rand) er_seen++;
        if (note_done) done_seen++;
        if (note_on) on_run++;
        else if (on_run != 0) begin last_run = on_run; on_run = 0; end
    endtask

    initial begin
        int cnt0, d0, e0, prev, done_since, wraps;
        bit first;
        done_seen = 0; er_seen = 0; on_run = 0; last_run = 0;
        model_reset();
        reset = 1'b1; play_en = 1'b0; rand_length = 2'd0; rand_note = 4'd0;

        // 1: asynchronous reset before any clock edge, then held 5 cycles
        #1 reset = 1'b0;
        #1 check("reset_no_clk");
        for (int i = 0; i < 5; i++) step("reset_hold");

        // 2: length 2 (3 beats), note 5
        reset = 1'b1; play_en = 1'b1; rand_length = 2'd2; rand_note = 4'd5;
        for (int i = 0; i < 18; i++) step("note_len2");
        expect_int("enable_pulses", er_seen, 2);
        expect_int("done_pulses", done_seen, 1);
        expect_int("gate_len12", last_run, 12);
        expect_int("count_after1", note_count, 1);

        // 3: note 14 folds to 2 with 1 beat; note 11 with 4 beats
        rand_length = 2'd0; rand_note = 4'd14;
        for (int i = 0; i < 8; i++) step("note_fold");
        expect_int("gate_len4", last_run, 4);
        expect_int("note_fold_val", note_out, 2);
        rand_length = 2'd3; rand_note = 4'd11;
        for (int i = 0; i < 20; i++) step("note_len3");
        expect_int("gate_len16", last_run, 16);
        expect_int("note_11", note_out, 11);

        // 4: stop on the third PLAY cycle
        for (int i = 0; i < 4; i++) step("pre_stop");
        play_en = 1'b0;
        cnt0 = note_count; d0 = done_seen; e0 = er_seen;
        step("stop_edge");
        expect_int("stop_gate_off", note_on, 0);
        for (int i = 0; i < 10; i++) step("stopped");
        expect_int("stop_no_done", done_seen, d0);
        expect_int("stop_no_req", er_seen, e0);
        expect_int("stop_count", note_count, cnt0);

        // 5: reset mid-PLAY between edges, then restart
        play_en = 1'b1;
        for (int i = 0; i < 5; i++) step("pre_reset");
        #2 reset = 1'b0;
        #1 model_reset();
        check("reset_async");
        expect_int("reset_gate_off", note_on, 0);
        for (int i = 0; i < 3; i++) step("reset_low");
        reset = 1'b1;
        step("rel_arm");
        expect_int("rel_no_req_yet", Enable_rand, 0);
        step("rel_req");
        expect_int("rel_req", Enable_rand, 1);
        for (int i = 0; i < 20; i++) step("restart");

        // 6: many short notes across the count wrap
        rand_length = 2'd0;
        prev = note_count; done_since = 0; wraps = 0; first = 1;
        for (int i = 0; i < 2200; i++) begin
            rand_note = 4'($urandom_range(0, 15));
            step("wrap_run");
            if (note_done) done_since++;
            if (int'(note_count) != prev) begin
                expect_int("count_step", note_count, (prev + 1) % 256);
                if (!first) expect_int("one_done_per_note", done_since, 1);
                if (prev == 255) wraps++;
                first = 0; done_since = 0; prev = note_count;
            end
        end
        expect_int("wrap_seen", wraps, 1);

        // 7: random inputs every cycle with occasional stops
        for (int i = 0; i < 800; i++) begin
            rand_length = 2'($urandom_range(0, 3));
            rand_note   = 4'($urandom_range(0, 15));
            play_en     = ($urandom_range(0, 49) != 0);
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
